// File: rtl/pool_job_scheduler.sv
// Round-robin job scheduler sharing one pooling unit between N_REQ requesters.
// Grants one job at a time, issues a start pulse, waits for done under a
// watchdog, and returns a tagged completion status.
module pool_job_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*3-1:0] req_inst,
    input  logic [N_REQ*3-1:0] req_dim,
    output logic               start_pool,
    output logic [2:0]         pooling_inst,
    output logic [2:0]         array_dim,
    input  logic               pu_done,
    output logic               cmp_valid,
    input  logic               cmp_ready,
    output logic [ID_W-1:0]    cmp_id,
    output logic [1:0]         cmp_status,
    output logic               busy,
    output logic [7:0]         timeout_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam logic [1:0] STS_OK      = 2'b00;
    localparam logic [1:0] STS_BAD_DIM = 2'b01;
    localparam logic [1:0] STS_TIMEOUT = 2'b10;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             start_nxt;
    logic [2:0]       inst_nxt, dim_nxt;
    logic             cmp_valid_nxt;
    logic [ID_W-1:0]  cmp_id_nxt;
    logic [1:0]       cmp_status_nxt;
    logic             busy_nxt;
    logic [7:0]       tocnt_nxt;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic [2:0]       sel_inst, sel_dim;
    logic             dim_ok;

    // Round-robin search: first valid requester at or after rr_ptr
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr) + i) % N_REQ);
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign sel_inst = req_inst[int'(grant_idx)*3 +: 3];
    assign sel_dim  = req_dim[int'(grant_idx)*3 +: 3];
    assign dim_ok   = (sel_dim == 3'd3) || (sel_dim == 3'd4) || (sel_dim == 3'd5);

    // Accept is offered only while idle, to the granted requester alone
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        timer_nxt      = timer;
        start_nxt      = 1'b0;
        inst_nxt       = pooling_inst;
        dim_nxt        = array_dim;
        cmp_valid_nxt  = cmp_valid;
        cmp_id_nxt     = cmp_id;
        cmp_status_nxt = cmp_status;
        tocnt_nxt      = timeout_cnt;

        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    inst_nxt   = sel_inst;
                    dim_nxt    = sel_dim;
                    cmp_id_nxt = grant_idx;
                    rr_ptr_nxt = ID_W'((32'(grant_idx) + 32'd1) % N_REQ);
                    if (dim_ok) begin
                        state_nxt = ST_ISSUE;
                        start_nxt = 1'b1;
                    end else begin
                        state_nxt      = ST_REPORT;
                        cmp_valid_nxt  = 1'b1;
                        cmp_status_nxt = STS_BAD_DIM;
                    end
                end
            end
            ST_ISSUE: begin
                timer_nxt = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                timer_nxt = timer + TMR_W'(1);
                if (pu_done) begin
                    state_nxt      = ST_REPORT;
                    cmp_valid_nxt  = 1'b1;
                    cmp_status_nxt = STS_OK;
                end else if (timer == TMR_LAST) begin
                    state_nxt      = ST_REPORT;
                    cmp_valid_nxt  = 1'b1;
                    cmp_status_nxt = STS_TIMEOUT;
                    if (timeout_cnt != 8'hFF) begin
                        tocnt_nxt = timeout_cnt + 8'd1;
                    end
                end
            end
            ST_REPORT: begin
                if (cmp_ready) begin
                    cmp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            timer        <= '0;
            start_pool   <= 1'b0;
            pooling_inst <= 3'd0;
            array_dim    <= 3'd0;
            cmp_valid    <= 1'b0;
            cmp_id       <= '0;
            cmp_status   <= 2'b00;
            busy         <= 1'b0;
            timeout_cnt  <= 8'd0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_ptr_nxt;
            timer        <= timer_nxt;
            start_pool   <= start_nxt;
            pooling_inst <= inst_nxt;
            array_dim    <= dim_nxt;
            cmp_valid    <= cmp_valid_nxt;
            cmp_id       <= cmp_id_nxt;
            cmp_status   <= cmp_status_nxt;
            busy         <= busy_nxt;
            timeout_cnt  <= tocnt_nxt;
        end
    end

endmodule

// File: tb/tb_pool_job_scheduler.sv
// Randomized self-checking bench for pool_job_scheduler with a job-level model.
module tb_pool_job_scheduler;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_inst;
    logic [11:0] req_dim;
    logic        start_pool;
    logic [2:0]  pooling_inst;
    logic [2:0]  array_dim;
    logic        pu_done;
    logic        cmp_valid;
    logic        cmp_ready;
    logic [1:0]  cmp_id;
    logic [1:0]  cmp_status;
    logic        busy;
    logic [7:0]  timeout_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: round-robin pointer and timeout counter
    int rr_m    = 0;
    int tocnt_m = 0;
    logic [2:0] inst_a [4];
    logic [2:0] dim_a  [4];

    pool_job_scheduler #(
        .N_REQ  (4),
        .ID_W   (2),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_inst    (req_inst),
        .req_dim     (req_dim),
        .start_pool  (start_pool),
        .pooling_inst(pooling_inst),
        .array_dim   (array_dim),
        .pu_done     (pu_done),
        .cmp_valid   (cmp_valid),
        .cmp_ready   (cmp_ready),
        .cmp_id      (cmp_id),
        .cmp_status  (cmp_status),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Spec arbitration rule: first valid from rr upward, modulo N
    function automatic int arb(input int rr, input logic [3:0] mask);
        logic [3:0] m;
        for (int i = 0; i < N; i++) begin
            m = mask >> ((rr + i) % N);
            if (m[0]) return (rr + i) % N;
        end
        return 0;
    endfunction

    task automatic load_reqs();
        for (int i = 0; i < N; i++) begin
            req_inst[i*3 +: 3] = inst_a[i];
            req_dim[i*3 +: 3]  = dim_a[i];
        end
    endtask

    task automatic rand_reqs(input bit allow_bad);
        for (int i = 0; i < N; i++) begin
            inst_a[i] = 3'($urandom);
            if (allow_bad && $urandom_range(0, 4) == 0) dim_a[i] = 3'($urandom);
            else dim_a[i] = 3'($urandom_range(3, 5));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, 32'(req_ready), 0);
        check_val({tag, "_start_pool"}, 32'(start_pool), 0);
        check_val({tag, "_pooling_inst"}, 32'(pooling_inst), 0);
        check_val({tag, "_array_dim"}, 32'(array_dim), 0);
        check_val({tag, "_cmp_valid"}, 32'(cmp_valid), 0);
        check_val({tag, "_cmp_id"}, 32'(cmp_id), 0);
        check_val({tag, "_cmp_status"}, 32'(cmp_status), 0);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_timeout_cnt"}, 32'(timeout_cnt), 0);
    endtask

    // Entered and left at posedge+1 with the DUT idle
    task automatic do_job(input logic [3:0] mask, input int done_dly, input int rdy_dly,
                          input bit done_in_issue);
        int g;
        logic [1:0] gi;
        logic [2:0] ei, ed;
        bit legal;
        logic [1:0] st;
        g     = arb(rr_m, mask);
        gi    = 2'(g);
        ei    = inst_a[gi];
        ed    = dim_a[gi];
        legal = (ed >= 3'd3) && (ed <= 3'd5);
        load_reqs();
        req_valid = mask;
        pu_done   = 1'b0;
        cmp_ready = 1'b0;
        @(negedge clk);
        check_val("grant", 32'(req_ready), 32'(4'b0001 << gi));
        check_val("busy_idle", 32'(busy), 0);
        @(posedge clk); #1;
        pu_done = done_in_issue;
        rr_m = (g + 1) % N;
        @(negedge clk);
        check_val("start_pool", 32'(start_pool), legal ? 1 : 0);
        check_val("inst_latched", 32'(pooling_inst), 32'(ei));
        check_val("dim_latched", 32'(array_dim), 32'(ed));
        check_val("busy_job", 32'(busy), 1);
        check_val("ready_busy", 32'(req_ready), 0);
        st = 2'b01;
        if (legal) begin
            check_val("cmp_valid_issue", 32'(cmp_valid), 0);
            @(posedge clk); #1;
            pu_done = 1'b0;
            st = 2'b10;
            for (int k = 0; k < TO; k++) begin
                pu_done = (k == done_dly);
                @(negedge clk);
                check_val("wait_no_cmp", 32'(cmp_valid), 0);
                check_val("wait_no_start", 32'(start_pool), 0);
                check_val("wait_ready", 32'(req_ready), 0);
                check_val("wait_inst_held", 32'(pooling_inst), 32'(ei));
                check_val("wait_dim_held", 32'(array_dim), 32'(ed));
                @(posedge clk); #1;
                pu_done = 1'b0;
                if (k == done_dly) begin
                    st = 2'b00;
                    break;
                end
            end
            if (st == 2'b10 && tocnt_m < 255) tocnt_m++;
        end
        for (int r = 0; r <= rdy_dly; r++) begin
            cmp_ready = (r == rdy_dly);
            pu_done   = 1'($urandom_range(0, 1));
            if (legal || r > 0) @(negedge clk);
            check_val("cmp_valid", 32'(cmp_valid), 1);
            check_val("cmp_id", 32'(cmp_id), 32'(gi));
            check_val("cmp_status", 32'(cmp_status), 32'(st));
            check_val("report_ready", 32'(req_ready), 0);
            check_val("report_busy", 32'(busy), 1);
            check_val("report_start", 32'(start_pool), 0);
            check_val("report_timeout_cnt", 32'(timeout_cnt), 32'(tocnt_m));
            check_val("report_dim_held", 32'(array_dim), 32'(ed));
            @(posedge clk); #1;
        end
        cmp_ready = 1'b0;
        req_valid = 4'b0000;
        pu_done   = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_val("post_cmp_valid", 32'(cmp_valid), 0);
        check_val("post_busy", 32'(busy), 0);
        check_val("post_start", 32'(start_pool), 0);
        check_val("post_timeout_cnt", 32'(timeout_cnt), 32'(tocnt_m));
        @(posedge clk); #1;
        pu_done = 1'b0;
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        rr_m    = 0;
        tocnt_m = 0;
    endtask

    // Reset while a job is waiting for done
    task automatic reset_mid_wait();
        rand_reqs(0);
        load_reqs();
        req_valid = 4'b1111;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        nrst      = 1'b0;
        #1;
        check_reset_outputs("mid_wait_rst");
        rr_m    = 0;
        tocnt_m = 0;
        @(posedge clk); #1;
        nrst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst      = 1'b0;
        req_valid = 4'b0000;
        req_inst  = 12'd0;
        req_dim   = 12'd0;
        pu_done   = 1'b0;
        cmp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            inst_a[i] = 3'd0;
            dim_a[i]  = 3'd3;
        end
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        nrst = 1'b1;

        // Single job: requester 1, inst 5, dim 4, done 12 cycles after start
        inst_a[1] = 3'd5;
        dim_a[1]  = 3'd4;
        do_job(4'b0010, 11, 0, 1'b0);

        // Fairness with all requesters held valid, pointer wraps 3->0
        apply_reset();
        for (int j = 0; j < 6; j++) begin
            rand_reqs(0);
            do_job(4'b1111, $urandom_range(0, 8), 0, j == 2);
        end

        // Illegal dimension from requester 2, then pointer must sit at 3
        rand_reqs(0);
        dim_a[2] = 3'd6;
        do_job(4'b0100, 0, 0, 1'b0);
        rand_reqs(0);
        do_job(4'b1111, 2, 0, 1'b0);

        // Timeout with the consumer stalling 5 cycles
        rand_reqs(0);
        do_job(4'b0001, 100, 5, 1'b0);

        // Done on the final wait cycle
        rand_reqs(0);
        do_job(4'b0010, TO - 1, 0, 1'b0);

        // Done during issue is ignored
        rand_reqs(0);
        do_job(4'b1000, 4, 1, 1'b1);
        rand_reqs(0);
        do_job(4'b0100, 100, 0, 1'b1);

        // Randomized traffic
        repeat (40) begin
            rand_reqs(1);
            do_job(4'($urandom_range(1, 15)), $urandom_range(0, 20), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        // Reset mid-job, then requester 0 wins first
        reset_mid_wait();
        rand_reqs(0);
        do_job(4'b1111, 3, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_job_scheduler.md
Name: pool_job_scheduler

Overview:
Shares one pooling unit and its address/sequence controller between N_REQ requesters, such as per-channel conv output drains. It accepts pooling jobs over per-requester valid/ready and arbitrates them round-robin. Each granted job is issued to the pooling controller as a one-cycle start pulse with stable instruction and array dimension. The block then waits for done, with a watchdog timeout, and returns a tagged completion status.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester index width, must equal clog2(N_REQ)
TIMEOUT, 64, max cycles in WAIT before the job is aborted (>=16)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester job request
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_inst  in  N_REQ x 3  pooling instruction per requester; bit2 = max(1)/avg(0)
req_dim  in  N_REQ x 3  array dimension per requester; legal values 3, 4, 5
start_pool  out  1  one-cycle start pulse to the pooling controller
pooling_inst  out  3  latched instruction, held ISSUE through REPORT
array_dim  out  3  latched dimension, held ISSUE through REPORT
pu_done  in  1  done pulse from the pooling controller
cmp_valid  out  1  completion available
cmp_ready  in  1  completion consumer accept
cmp_id  out  ID_W  requester index of the completed job
cmp_status  out  2  00 ok, 01 bad dim, 10 timeout, 11 reserved
busy  out  1  state != IDLE
timeout_cnt  out  8  saturating count of timed-out jobs

Behaviour:
- Reset values: state IDLE; rr_ptr 0; req_ready 0; start_pool 0; pooling_inst 0; array_dim 0; cmp_valid 0; cmp_id 0; cmp_status 0; timer 0; timeout_cnt 0; busy 0. Reset is honoured in any state, including mid-WAIT. Reset does not drive start_pool or emit a completion.
- States: IDLE, ISSUE, WAIT, REPORT.
- IDLE:
  - Grant g = first requester with req_valid=1, searching from rr_ptr upward modulo N_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - On handshake: latch req_inst[g], req_dim[g] and g; set rr_ptr = (g+1) mod N_REQ.
  - If the latched dim is not 3/4/5, go to REPORT with status 01 and no start_pool. Otherwise go to ISSUE.
  - With no req_valid, stay in IDLE with rr_ptr unchanged.
- ISSUE:
  - start_pool=1 for exactly one cycle; timer cleared to 0; go to WAIT.
  - pu_done seen in this cycle is ignored.
- WAIT:
  - timer increments by 1 each cycle.
  - pu_done=1: go to REPORT with status 00.
  - Otherwise, timer==TIMEOUT-1: go to REPORT with status 10, and timeout_cnt increments, saturating at 255.
  - pu_done and the timeout condition in the same cycle: done wins, status 00.
- REPORT:
  - cmp_valid=1, with cmp_id and cmp_status stable until cmp_ready=1.
  - Handshake cycle: cmp_valid falls next cycle, state goes to IDLE.
  - cmp_ready already high on entry completes in one cycle.
  - req_ready stays 0 while in REPORT, so there is no accept overlap.
- pu_done outside WAIT is ignored with no state effect.
- Latency:
  - req handshake at cycle T, start_pool at T+1, WAIT from T+2.
  - pu_done at cycle D gives cmp_valid from D+1.
  - Minimum request-to-request turnaround is 4 cycles.
- Width rules:
  - timer width is clog2(TIMEOUT)+1; no wrap is possible because exit occurs at TIMEOUT-1.
  - rr_ptr wraps from N_REQ-1 to 0.
- pooling_inst and array_dim change only on an IDLE handshake, never mid-job.

Test Plan:
- Single job: req_valid[1]=1, inst=3'b101, dim=4; pu_done 12 cycles after start. Expect:
  - req_ready[1] in the same cycle and start_pool exactly once one cycle later.
  - pooling_inst=5 and array_dim=4 held stable.
  - cmp_valid with cmp_id=1, cmp_status=00; busy low after cmp_ready.
- Round-robin fairness: all 4 req_valid held high, each job finished by pu_done. Expect grant order 0,1,2,3,0,1, with rr_ptr wrap 3->0 verified.
- Illegal dim: requester 2 sends dim=6. Expect:
  - No start_pool.
  - cmp_id=2, cmp_status=01 at T+1.
  - rr_ptr advanced to 3.
- Timeout: TIMEOUT=16 with no pu_done. Expect:
  - REPORT entered exactly 16 cycles after the WAIT entry cycle.
  - cmp_status=10 and timeout_cnt=1.
  - A late pu_done arriving in REPORT/IDLE is ignored.
- Boundaries:
  - pu_done asserted on the final WAIT cycle (timer=15): status 00, timeout_cnt unchanged.
  - pu_done asserted in the ISSUE cycle: ignored.
  - cmp_ready held low 5 cycles: cmp outputs stable and req_ready stays 0 throughout.
- Reset mid-WAIT: nrst pulled low with the job pending. Expect:
  - All outputs return to reset values immediately.
  - After release, rr_ptr=0 and requester 0 is granted first with all requesters valid.
